maxnet_winner_capture: RTL and testbench
========================================

# maxnet_winner_capture

Downstream consumer of the four-PU MaxNet datapath. It tracks the iterations of a run, watches the `S` flag and the four PU outputs, and decides when the competition has ended. It then latches the winner's index, value and iteration count into an output buffer held under a valid/ready handshake, and sends a one-cycle `stop` to the controller so iteration halts.

## Interface
Parameters:
- `W`, 5: PU output width; matches the datapath's 5-bit words.
- `CNT_W`, 5: iteration counter width.
- `MAX_ITER`, 20: iteration limit. Used only when `MAXNET_TIMEOUT_EN` is defined. Legal range is 1 to 2^CNT_W-1.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: one-cycle pulse from the controller when new inputs are loaded (the cycle of `input_en`).
- `iter_done`  in  1: one-cycle pulse; `pu_out1..4` and `S` are valid this cycle for the iteration just completed.
- `S`  in  1: datapath flag; exactly one PU output is nonzero.
- `pu_out1`..`pu_out4`  in  W each: PU outputs, unsigned.
- `stop`  out  1: one-cycle pulse telling the controller the run has ended.
- `busy`  out  1: high in RUN and HOLD.
- `res_valid`  out  1: result buffer holds a result.
- `res_ready`  in  1: consumer accepts the result.
- `res_idx`  out  2: winner index, 0 to 3 (`pu_out1` = 0).
- `res_val`  out  W: winner's output value.
- `res_iters`  out  CNT_W: number of `iter_done` pulses counted in the run.
- `res_none`  out  1: all four outputs were zero; no winner.
- `res_timeout`  out  1: run ended at `MAX_ITER` without `S`.

## Operation
- The FSM has three states: IDLE, RUN and HOLD. Reset enters IDLE.
- Reset values: `stop`=0, `busy`=0, `res_valid`=0, `res_idx`=0, `res_val`=0, `res_iters`=0, `res_none`=0, `res_timeout`=0. The counter resets to 0.
- IDLE:
  - `start` → RUN; counter cleared.
  - `iter_done` is ignored.
- RUN: on `iter_done`, the next count is `cnt+1`. The termination conditions are evaluated in priority order:
  1. `S`=1 → winner is the single nonzero output. If the data contradicts `S` (more than one nonzero), the lowest nonzero index is taken.
  2. All four outputs are 0 → `res_none`=1, `res_idx`=0, `res_val`=0.
  3. Timeout (see Configuration) → `res_timeout`=1. Winner is the largest output, with the lowest index winning a tie.
  - On any termination: the result fields load with `res_iters`=`cnt+1`, and the FSM moves to HOLD.
  - Otherwise the counter stores `cnt+1` and the FSM stays in RUN.
- `start` during RUN restarts the run: counter cleared to 0, state stays RUN, and no result is produced.
- The counter saturates at 2^CNT_W-1 and never wraps.
- HOLD:
  - `res_valid`=1; all `res_*` fields are stable until the handshake completes.
  - The cycle with `res_valid`&&`res_ready` → IDLE.
  - `start` and `iter_done` are ignored in HOLD; the controller must wait for `busy`=0.
- If `start` arrives in the same cycle as the accept, the FSM goes directly to RUN (counter cleared) and `res_valid` falls.

## Timing
- The termination decision is registered: `stop` and `res_valid` rise in the cycle after the terminating `iter_done`. `stop` lasts exactly one cycle.
- `busy` rises the cycle after `start`. It falls the cycle after the accepting handshake, unless a same-cycle `start` takes the FSM directly to RUN, in which case `busy` stays high.
- `res_valid` falls the cycle after `res_valid`&&`res_ready`.
- `res_ready` may be held high permanently; the result is still visible for at least one cycle.
- Comparators are combinational on `pu_out*`. Only registered state drives the outputs.
- `rst` mid-run or in HOLD: the next cycle is IDLE with all outputs at their reset values. Any pending result is discarded.

## Configuration
- `MAXNET_TIMEOUT_EN` defined:
  - Termination condition 3 is active: the run ends on the `iter_done` that makes `cnt+1`==`MAX_ITER` if neither `S` nor all-zero holds.
  - `res_timeout` is driven.
- `MAXNET_TIMEOUT_EN` undefined:
  - No iteration limit; the run continues until `S` or all-zero.
  - `res_timeout` is tied to 0, and the max-comparator logic is not built.

## Test plan
- **Basic win:** `start`, then three `iter_done` with `S`=0 and nonzero outputs, then a fourth with `S`=1 and outputs (0,0,7,0) → `stop` pulse; `res_idx`=2, `res_val`=7, `res_iters`=4, `res_none`=0.
- **All-zero collapse:** `start`, one `iter_done` with outputs (0,0,0,0) and `S`=0 → `res_none`=1, `res_idx`=0, `res_iters`=1.
- **Timeout** (`MAXNET_TIMEOUT_EN`, `MAX_ITER`=3): three `iter_done` with (5,9,9,2) and `S`=0 → `res_timeout`=1, `res_idx`=1, `res_val`=9, `res_iters`=3. Without the macro, the same stimulus gives no `stop` and `busy` stays 1.
- **Handshake backpressure:** `res_ready`=0 for 5 cycles after `res_valid` → fields stable and `iter_done` pulses ignored. Then `res_ready`=1 → `res_valid` low and `busy` low the next cycle.
- **Restart and reset:** `start` after 2 iterations → the next win reports `res_iters` counted from the restart. Separately, assert `rst` in HOLD → all outputs 0 the next cycle.

Source files
------------

// File: rtl/maxnet_winner_capture.sv
// Watches a four-PU MaxNet run, decides when it has ended and holds the winner behind valid/ready.
// Define MAXNET_TIMEOUT_EN to end runs at MAX_ITER iterations and pick the largest output.
module maxnet_winner_capture #(
  parameter int W        = 5,
  parameter int CNT_W    = 5,
  parameter int MAX_ITER = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             iter_done,
  input  logic             S,
  input  logic [W-1:0]     pu_out1,
  input  logic [W-1:0]     pu_out2,
  input  logic [W-1:0]     pu_out3,
  input  logic [W-1:0]     pu_out4,
  output logic             stop,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [1:0]       res_idx,
  output logic [W-1:0]     res_val,
  output logic [CNT_W-1:0] res_iters,
  output logic             res_none,
  output logic             res_timeout
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_inc;
  logic [W-1:0]     pu [4];
  logic             all_zero, timed_out, terminate;
  logic [1:0]       s_idx, win_idx;
  logic [W-1:0]     s_val, win_val;
  logic             win_none;

  assign pu[0] = pu_out1;
  assign pu[1] = pu_out2;
  assign pu[2] = pu_out3;
  assign pu[3] = pu_out4;

  assign cnt_inc  = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
  assign all_zero = (pu[0] == '0) && (pu[1] == '0) && (pu[2] == '0) && (pu[3] == '0);

  // Lowest nonzero index wins when S is asserted on inconsistent data.
  always_comb begin
    s_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pu[i] != '0) s_idx = 2'(i);
    end
  end

  assign s_val = pu[s_idx];

`ifdef MAXNET_TIMEOUT_EN
  logic [1:0]   m_idx;
  logic [W-1:0] m_val;
  logic         win_timeout;
  logic         res_timeout_r;

  always_comb begin
    m_idx = 2'd0;
    m_val = pu[0];
    for (int i = 1; i < 4; i++) begin
      if (pu[i] > m_val) begin
        m_idx = 2'(i);
        m_val = pu[i];
      end
    end
  end

  assign timed_out   = (cnt_inc == CNT_W'(MAX_ITER));
  assign res_timeout = res_timeout_r;
`else
  logic unused_max_iter;

  assign unused_max_iter = ^CNT_W'(MAX_ITER);
  assign timed_out       = 1'b0;
  assign res_timeout     = 1'b0;
`endif

  // Termination priority: S, then all-zero, then the iteration limit.
  always_comb begin
    win_idx  = s_idx;
    win_val  = s_val;
    win_none = 1'b0;
`ifdef MAXNET_TIMEOUT_EN
    win_timeout = 1'b0;
`endif
    if (!S && all_zero) begin
      win_idx  = 2'd0;
      win_val  = '0;
      win_none = 1'b1;
    end
`ifdef MAXNET_TIMEOUT_EN
    else if (!S && timed_out) begin
      win_idx     = m_idx;
      win_val     = m_val;
      win_timeout = 1'b1;
    end
`endif
  end

  assign terminate = (state == RUN) && iter_done && !start && (S || all_zero || timed_out);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (terminate) state_next = HOLD;
      HOLD:    if (res_ready) state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    res_valid = (state == HOLD);
  end

  // A start is honoured anywhere except a HOLD that is not being accepted.
  always_ff @(posedge clk) begin
    if (rst)                                        cnt <= '0;
    else if (start && (state != HOLD || res_ready)) cnt <= '0;
    else if (state == RUN && iter_done)             cnt <= cnt_inc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stop      <= 1'b0;
      res_idx   <= 2'd0;
      res_val   <= '0;
      res_iters <= '0;
      res_none  <= 1'b0;
`ifdef MAXNET_TIMEOUT_EN
      res_timeout_r <= 1'b0;
`endif
    end else begin
      stop <= terminate;
      if (terminate) begin
        res_idx   <= win_idx;
        res_val   <= win_val;
        res_iters <= cnt_inc;
        res_none  <= win_none;
`ifdef MAXNET_TIMEOUT_EN
        res_timeout_r <= win_timeout;
`endif
      end
    end
  end

endmodule

// File: tb/tb_maxnet_winner_capture.sv
// Self-checking bench for maxnet_winner_capture: directed scenarios plus randomized runs
// checked against a run-level reference model; follows MAXNET_TIMEOUT_EN when defined.
module tb_maxnet_winner_capture;

  localparam int W        = 5;
  localparam int CNT_W    = 5;
  localparam int MAX_ITER = 3;
  localparam int CNT_SAT  = (1 << CNT_W) - 1;
`ifdef MAXNET_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic             clk, rst, start, iter_done, S, res_ready;
  logic [W-1:0]     pu_out1, pu_out2, pu_out3, pu_out4;
  logic             stop, busy, res_valid, res_none, res_timeout;
  logic [1:0]       res_idx;
  logic [W-1:0]     res_val;
  logic [CNT_W-1:0] res_iters;

  typedef struct packed {
    logic              s;
    logic [3:0][W-1:0] o;
  } iter_t;

  iter_t       stim[$];
  int          checks = 0;
  int          errors = 0;
  int          exp_end, exp_iters, stop_at;
  logic [1:0]  exp_idx;
  logic [W-1:0] exp_val;
  logic        exp_none, exp_to;

  maxnet_winner_capture #(.W(W), .CNT_W(CNT_W), .MAX_ITER(MAX_ITER)) dut (
    .clk(clk), .rst(rst), .start(start), .iter_done(iter_done), .S(S),
    .pu_out1(pu_out1), .pu_out2(pu_out2), .pu_out3(pu_out3), .pu_out4(pu_out4),
    .stop(stop), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
    .res_idx(res_idx), .res_val(res_val), .res_iters(res_iters),
    .res_none(res_none), .res_timeout(res_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic iter_t mk(input int a, input int b, input int c, input int d, input bit s);
    iter_t t;
    t.s    = s;
    t.o[0] = W'(a);
    t.o[1] = W'(b);
    t.o[2] = W'(c);
    t.o[3] = W'(d);
    return t;
  endfunction

  // Walks the stimulus iteration by iteration and records where and how the run should end.
  function automatic void model_run();
    int n = 0;
    int best;
    exp_end = -1; exp_idx = 2'd0; exp_val = '0; exp_iters = 0; exp_none = 1'b0; exp_to = 1'b0;
    foreach (stim[k]) begin
      n = (n < CNT_SAT) ? n + 1 : CNT_SAT;
      if (stim[k].s) begin
        best = 0;
        for (int i = 3; i >= 0; i--) if (stim[k].o[i] != 0) best = i;
        exp_idx = 2'(best); exp_val = stim[k].o[best]; exp_iters = n; exp_end = k;
        return;
      end
      if (stim[k].o == '0) begin
        exp_none = 1'b1; exp_iters = n; exp_end = k;
        return;
      end
      if (TIMEOUT_ON && n == MAX_ITER) begin
        best = 0;
        for (int i = 1; i < 4; i++) if (stim[k].o[i] > stim[k].o[best]) best = i;
        exp_idx = 2'(best); exp_val = stim[k].o[best]; exp_to = 1'b1; exp_iters = n; exp_end = k;
        return;
      end
    end
  endfunction

  // Plays the queued iterations (optionally after a start) and notes where stop appeared.
  task automatic drive_run(input bit do_start, input int gap_max);
    if (do_start) begin
      start = 1'b1;
      cycle();
      start = 1'b0;
    end
    stop_at = -1;
    foreach (stim[k]) begin
      repeat ($urandom_range(gap_max, 0)) begin
        cycle();
        if (stop) stop_at = -2;
      end
      pu_out1 = stim[k].o[0]; pu_out2 = stim[k].o[1];
      pu_out3 = stim[k].o[2]; pu_out4 = stim[k].o[3];
      S = stim[k].s;
      iter_done = 1'b1;
      cycle();
      iter_done = 1'b0;
      S = 1'b0;
      if (stop) begin
        stop_at = (stop_at == -1) ? k : -2;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++; if (stop !== 1'b0) begin errors++; $display("[TB] FAIL reset_stop got %0b want 0", stop); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b want 0", busy); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0b want 0", res_valid); end
    checks++; if (res_idx !== 2'd0) begin errors++; $display("[TB] FAIL reset_idx got %0d want 0", res_idx); end
    checks++; if (res_val !== '0) begin errors++; $display("[TB] FAIL reset_val got %0d want 0", res_val); end
    checks++; if (res_iters !== '0) begin errors++; $display("[TB] FAIL reset_iters got %0d want 0", res_iters); end
    checks++; if (res_none !== 1'b0) begin errors++; $display("[TB] FAIL reset_none got %0b want 0", res_none); end
    checks++; if (res_timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout got %0b want 0", res_timeout); end
  endtask

  task automatic test_basic_win();
    stim.delete();
    stim.push_back(mk(3, 5, 4, 6, 0));
    stim.push_back(mk(2, 4, 3, 5, 0));
    stim.push_back(mk(1, 2, 6, 3, 0));
    stim.push_back(mk(0, 0, 7, 0, 1));
    model_run();
    res_ready = 1'b0;
    drive_run(1'b1, 0);
    checks++; if (stop_at !== exp_end) begin errors++; $display("[TB] FAIL basic_stop_at got %0d want %0d", stop_at, exp_end); end
    checks++; if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid got %0b want 1", res_valid); end
    checks++; if ({res_idx, res_val, res_iters, res_none, res_timeout} !== {exp_idx, exp_val, CNT_W'(exp_iters), exp_none, exp_to}) begin
      errors++; $display("[TB] FAIL basic_fields got idx=%0d val=%0d it=%0d none=%0b to=%0b want idx=%0d val=%0d it=%0d none=%0b to=%0b",
        res_idx, res_val, res_iters, res_none, res_timeout, exp_idx, exp_val, exp_iters, exp_none, exp_to);
    end
`ifndef MAXNET_TIMEOUT_EN
    checks++; if ({res_idx, res_val, res_iters, res_none} !== {2'd2, 5'd7, 5'd4, 1'b0}) begin
      errors++; $display("[TB] FAIL basic_plan got idx=%0d val=%0d it=%0d none=%0b want idx=2 val=7 it=4 none=0", res_idx, res_val, res_iters, res_none);
    end
`endif
    cycle();
    checks++; if (stop !== 1'b0) begin errors++; $display("[TB] FAIL basic_stop_pulse got %0b want 0", stop); end
    checks++; if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid_held got %0b want 1", res_valid); end
    res_ready = 1'b1;
    cycle();
    res_ready = 1'b0;
    checks++; if ({res_valid, busy} !== 2'b00) begin errors++; $display("[TB] FAIL basic_accept got valid/busy=%b want 00", {res_valid, busy}); end
  endtask

  task automatic test_all_zero();
    stim.delete();
    stim.push_back(mk(0, 0, 0, 0, 0));
    model_run();
    res_ready = 1'b1;
    drive_run(1'b1, 0);
    checks++; if (stop_at !== exp_end) begin errors++; $display("[TB] FAIL zero_stop_at got %0d want %0d", stop_at, exp_end); end
    checks++; if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL zero_valid got %0b want 1", res_valid); end
    checks++; if ({res_idx, res_val, res_iters, res_none} !== {2'd0, 5'd0, 5'd1, 1'b1}) begin
      errors++; $display("[TB] FAIL zero_fields got idx=%0d val=%0d it=%0d none=%0b want idx=0 val=0 it=1 none=1", res_idx, res_val, res_iters, res_none);
    end
    cycle();
    res_ready = 1'b0;
    checks++; if ({res_valid, busy} !== 2'b00) begin errors++; $display("[TB] FAIL zero_ready_high got valid/busy=%b want 00", {res_valid, busy}); end
  endtask

  task automatic test_timeout();
    stim.delete();
    repeat (3) stim.push_back(mk(5, 9, 9, 2, 0));
    model_run();
    res_ready = 1'b0;
    drive_run(1'b1, 0);
    checks++; if (stop_at !== exp_end) begin errors++; $display("[TB] FAIL timeout_stop_at got %0d want %0d", stop_at, exp_end); end
    checks++; if (res_valid !== (exp_end >= 0)) begin errors++; $display("[TB] FAIL timeout_valid got %0b want %0b", res_valid, exp_end >= 0); end
    if (exp_end >= 0) begin
      checks++; if ({res_idx, res_val, res_iters, res_timeout} !== {2'd1, 5'd9, CNT_W'(MAX_ITER), 1'b1}) begin
        errors++; $display("[TB] FAIL timeout_fields got idx=%0d val=%0d it=%0d to=%0b want idx=1 val=9 it=%0d to=1", res_idx, res_val, res_iters, res_timeout, MAX_ITER);
      end
    end
    repeat (2) cycle();
    checks++; if ({busy, stop} !== 2'b10) begin errors++; $display("[TB] FAIL timeout_busy got busy/stop=%b want 10", {busy, stop}); end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_backpressure();
    stim.delete();
    stim.push_back(mk(4, 1, 2, 0, 0));
    stim.push_back(mk(0, 3, 0, 0, 1));
    model_run();
    res_ready = 1'b0;
    drive_run(1'b1, 0);
    checks++; if (stop_at !== exp_end) begin errors++; $display("[TB] FAIL bp_stop_at got %0d want %0d", stop_at, exp_end); end
    for (int c = 0; c < 5; c++) begin
      pu_out1 = W'($urandom_range(31, 0)); pu_out2 = W'($urandom_range(31, 0));
      pu_out3 = W'($urandom_range(31, 0)); pu_out4 = W'($urandom_range(31, 0));
      S = 1'($urandom_range(1, 0));
      iter_done = 1'b1;
      cycle();
      checks++; if ({res_valid, stop, res_idx, res_val, res_iters, res_none} !== {2'b10, exp_idx, exp_val, CNT_W'(exp_iters), exp_none}) begin
        errors++; $display("[TB] FAIL bp_hold[%0d] got v=%0b s=%0b idx=%0d val=%0d it=%0d want v=1 s=0 idx=%0d val=%0d it=%0d",
          c, res_valid, stop, res_idx, res_val, res_iters, exp_idx, exp_val, exp_iters);
      end
    end
    iter_done = 1'b0;
    S = 1'b0;
    res_ready = 1'b1;
    cycle();
    res_ready = 1'b0;
    checks++; if ({res_valid, busy} !== 2'b00) begin errors++; $display("[TB] FAIL bp_accept got valid/busy=%b want 00", {res_valid, busy}); end
  endtask

  task automatic test_restart();
    stim.delete();
    stim.push_back(mk(3, 3, 3, 3, 0));
    stim.push_back(mk(3, 3, 3, 3, 0));
    drive_run(1'b1, 0);
    stim.delete();
    stim.push_back(mk(2, 2, 1, 1, 0));
    stim.push_back(mk(1, 2, 0, 1, 0));
    stim.push_back(mk(0, 0, 0, 9, 1));
    model_run();
    drive_run(1'b1, 1);
    checks++; if (stop_at !== exp_end) begin errors++; $display("[TB] FAIL restart_stop_at got %0d want %0d", stop_at, exp_end); end
    checks++; if ({res_idx, res_val, res_iters} !== {2'd3, 5'd9, 5'd3}) begin
      errors++; $display("[TB] FAIL restart_fields got idx=%0d val=%0d it=%0d want idx=3 val=9 it=3", res_idx, res_val, res_iters);
    end
    res_ready = 1'b1;
    cycle();
    res_ready = 1'b0;
  endtask

  task automatic test_start_on_accept();
    stim.delete();
    stim.push_back(mk(0, 6, 0, 0, 1));
    drive_run(1'b1, 0);
    res_ready = 1'b1;
    start = 1'b1;
    cycle();
    start = 1'b0;
    res_ready = 1'b0;
    checks++; if ({res_valid, busy, stop} !== 3'b010) begin errors++; $display("[TB] FAIL soa_state got valid/busy/stop=%b want 010", {res_valid, busy, stop}); end
    stim.delete();
    stim.push_back(mk(1, 1, 1, 1, 0));
    stim.push_back(mk(8, 0, 0, 0, 1));
    model_run();
    drive_run(1'b0, 0);
    checks++; if (stop_at !== exp_end) begin errors++; $display("[TB] FAIL soa_stop_at got %0d want %0d", stop_at, exp_end); end
    checks++; if ({res_idx, res_val, res_iters} !== {2'd0, 5'd8, 5'd2}) begin
      errors++; $display("[TB] FAIL soa_fields got idx=%0d val=%0d it=%0d want idx=0 val=8 it=2", res_idx, res_val, res_iters);
    end
    res_ready = 1'b1;
    cycle();
    res_ready = 1'b0;
  endtask

  task automatic test_reset_in_hold();
    stim.delete();
    stim.push_back(mk(0, 0, 0, 5, 1));
    drive_run(1'b1, 0);
    checks++; if (res_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_reset_pre got valid %0b want 1", res_valid); end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    checks++; if ({stop, busy, res_valid, res_idx, res_val, res_iters, res_none, res_timeout} !== '0) begin
      errors++; $display("[TB] FAIL hold_reset got s=%0b b=%0b v=%0b idx=%0d val=%0d it=%0d none=%0b to=%0b want all 0",
        stop, busy, res_valid, res_idx, res_val, res_iters, res_none, res_timeout);
    end
  endtask

  task automatic test_saturation();
    stim.delete();
    repeat (34) stim.push_back(mk(1, 2, 3, 4, 0));
    stim.push_back(mk(0, 5, 0, 0, 1));
    model_run();
    drive_run(1'b1, 0);
    checks++; if (stop_at !== exp_end) begin errors++; $display("[TB] FAIL sat_stop_at got %0d want %0d", stop_at, exp_end); end
    checks++; if ({res_idx, res_val, res_iters, res_timeout} !== {exp_idx, exp_val, CNT_W'(exp_iters), exp_to}) begin
      errors++; $display("[TB] FAIL sat_fields got idx=%0d val=%0d it=%0d to=%0b want idx=%0d val=%0d it=%0d to=%0b",
        res_idx, res_val, res_iters, res_timeout, exp_idx, exp_val, exp_iters, exp_to);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_random();
    iter_t t;
    int    len, j;
    for (int r = 0; r < 40; r++) begin
      stim.delete();
      len = $urandom_range(8, 1);
      for (int k = 0; k < len; k++) begin
        t.s = ($urandom_range(3, 0) == 0);
        for (int i = 0; i < 4; i++) t.o[i] = ($urandom_range(3, 0) == 0) ? '0 : W'($urandom_range(31, 1));
        if ($urandom_range(7, 0) == 0) t.o = '0;
        if (t.s) begin
          j = $urandom_range(3, 0);
          if ($urandom_range(1, 0) == 1) t.o = '0;
          if (t.o[j] == '0) t.o[j] = W'($urandom_range(31, 1));
        end
        stim.push_back(t);
      end
      model_run();
      res_ready = 1'b0;
      drive_run(1'b1, 2);
      checks++; if (stop_at !== exp_end) begin errors++; $display("[TB] FAIL rand%0d_stop_at got %0d want %0d", r, stop_at, exp_end); end
      if (exp_end >= 0) begin
        checks++; if ({res_valid, res_idx, res_val, res_iters, res_none, res_timeout} !== {1'b1, exp_idx, exp_val, CNT_W'(exp_iters), exp_none, exp_to}) begin
          errors++; $display("[TB] FAIL rand%0d_fields got v=%0b idx=%0d val=%0d it=%0d none=%0b to=%0b want v=1 idx=%0d val=%0d it=%0d none=%0b to=%0b",
            r, res_valid, res_idx, res_val, res_iters, res_none, res_timeout, exp_idx, exp_val, exp_iters, exp_none, exp_to);
        end
        repeat ($urandom_range(3, 0)) cycle();
        res_ready = 1'b1;
        cycle();
        res_ready = 1'b0;
        checks++; if ({res_valid, busy} !== 2'b00) begin errors++; $display("[TB] FAIL rand%0d_accept got valid/busy=%b want 00", r, {res_valid, busy}); end
      end else begin
        checks++; if ({busy, res_valid} !== 2'b10) begin errors++; $display("[TB] FAIL rand%0d_running got busy/valid=%b want 10", r, {busy, res_valid}); end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; iter_done = 1'b0; S = 1'b0; res_ready = 1'b0;
    pu_out1 = '0; pu_out2 = '0; pu_out3 = '0; pu_out4 = '0;
    test_reset();
    test_basic_win();
    test_all_zero();
    test_timeout();
    test_backpressure();
    test_restart();
    test_start_on_accept();
    test_reset_in_hold();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
